// File: rtl/router_pkg.sv
// router_pkg: shared port indices, flit field positions, lock states and XY routing
package router_pkg;
    localparam int NPORT = 5;
    localparam logic [2:0] P_CORE = 3'd0;
    localparam logic [2:0] P_E = 3'd1;
    localparam logic [2:0] P_N = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_S = 3'd4;
    localparam int FLIT_W_DEF = 34;
    localparam int HEAD_OFS = 1;
    localparam int TAIL_OFS = 2;
    localparam int DST_LSB_DEF = 24;
    localparam int DST_W_DEF = 4;
    typedef enum logic {IDLE, LOCKED} lock_t;
    // Dimension-ordered: resolve X first, then Y; N means decreasing y, ties go W / S
    function automatic logic [2:0] route_dir(input int id, input int dst, input int cols,
                                             input int rows, input int torus);
        int x, y, dx, dy, de, dw, dn, ds;
        x = id % cols;
        y = id / cols;
        dx = dst % cols;
        dy = dst / cols;
        if (dst == id || dst >= cols * rows) return P_CORE;
        if (dx != x) begin
            if (torus != 0) begin
                de = (dx - x + cols) % cols;
                dw = cols - de;
                return (de < dw) ? P_E : P_W;
            end
            return (dx > x) ? P_E : P_W;
        end
        if (torus != 0) begin
            dn = (y - dy + rows) % rows;
            ds = rows - dn;
            return (dn < ds) ? P_N : P_S;
        end
        return (dy < y) ? P_N : P_S;
    endfunction
endpackage

// File: rtl/router_in_fifo.sv
// router_in_fifo: per-input flit FIFO, no bypass path
module router_in_fifo #(
    parameter int FLIT_W = 34,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              pop,
    output logic [FLIT_W-1:0] flit_out,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    assign flit_out = mem[rp];
    assign full = cnt == (AW+1)'(FIFO_DEPTH);
    assign empty = cnt == '0;
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= flit_in;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/torus_router_rr.sv
// torus_router_rr: 5-port wormhole router, XY routing on torus or mesh, per-output RR lock
module torus_router_rr
    import router_pkg::*;
#(
    parameter int ID = 0,
    parameter int COLS = 3,
    parameter int ROWS = 3,
    parameter int FLIT_W = FLIT_W_DEF,
    parameter int DST_LSB = DST_LSB_DEF,
    parameter int DST_W = DST_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int TORUS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5*FLIT_W-1:0]     in_flit,
    input  logic [4:0]              in_req,
    output logic [4:0]              out_ack,
    output logic [5*FLIT_W-1:0]     out_flit,
    output logic [4:0]              out_req,
    input  logic [4:0]              in_ack,
    output logic                    err_bad_dst
);
    localparam int NODES = COLS * ROWS;
    logic [FLIT_W-1:0] hd [NPORT];
    logic [FLIT_W-1:0] oreg [NPORT];
    logic [2:0] rdir [NPORT];
    logic [2:0] sel [NPORT];
    logic [2:0] owner [NPORT];
    logic [2:0] rr [NPORT];
    lock_t lock [NPORT];
    lock_t lock_nxt [NPORT];
    logic [NPORT-1:0] full, empty, push, pop, owns, mv, oval, bad;
    logic err;
    int p;

    assign out_ack = rst ? '0 : ~full;
    assign push = in_req & out_ack;
    assign out_req = oval;
    assign err_bad_dst = err;

    for (genvar i = 0; i < NPORT; i++) begin : g_port
        router_in_fifo #(.FLIT_W(FLIT_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(clk),
            .rst(rst),
            .push(push[i]),
            .flit_in(in_flit[i*FLIT_W +: FLIT_W]),
            .pop(pop[i]),
            .flit_out(hd[i]),
            .full(full[i]),
            .empty(empty[i])
        );
        assign rdir[i] = route_dir(ID, int'(hd[i][DST_LSB +: DST_W]), COLS, ROWS, TORUS);
        assign bad[i] = int'(hd[i][DST_LSB +: DST_W]) >= NODES;
        assign out_flit[i*FLIT_W +: FLIT_W] = oreg[i];
    end

    always_comb begin
        owns = '0;
        mv = '0;
        pop = '0;
        err = 1'b0;
        p = 0;
        for (int o = 0; o < NPORT; o++) begin
            sel[o] = P_CORE;
            lock_nxt[o] = lock[o];
        end
        for (int o = 0; o < NPORT; o++) begin
            if (lock[o] == LOCKED) owns[owner[o]] = 1'b1;
        end
        for (int o = 0; o < NPORT; o++) begin
            if (lock[o] == LOCKED) begin
                sel[o] = owner[o];
                mv[o] = !empty[owner[o]] && (!oval[o] || in_ack[o]);
            end else begin
                for (int k = 0; k < NPORT; k++) begin
                    p = (int'(rr[o]) + k) % NPORT;
                    if (!mv[o] && !empty[p] && hd[p][FLIT_W-HEAD_OFS] && !owns[p] &&
                        int'(rdir[p]) == o && (!oval[o] || in_ack[o])) begin
                        mv[o] = 1'b1;
                        sel[o] = 3'(p);
                    end
                end
            end
            if (mv[o] && !rst) begin
                pop[sel[o]] = 1'b1;
                err = err | ((lock[o] == IDLE) && bad[sel[o]]);
                lock_nxt[o] = hd[sel[o]][FLIT_W-TAIL_OFS] ? IDLE : LOCKED;
            end
        end
        // body flits with no owning packet are dropped
        for (int q = 0; q < NPORT; q++) begin
            if (!rst && !empty[q] && !hd[q][FLIT_W-HEAD_OFS] && !owns[q]) pop[q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < NPORT; o++) begin
            if (rst) begin
                lock[o] <= IDLE;
                owner[o] <= '0;
                rr[o] <= '0;
                oval[o] <= 1'b0;
                oreg[o] <= '0;
            end else begin
                lock[o] <= lock_nxt[o];
                if (mv[o]) begin
                    oreg[o] <= hd[sel[o]];
                    oval[o] <= 1'b1;
                    if (lock[o] == IDLE) begin
                        owner[o] <= sel[o];
                        rr[o] <= (sel[o] == 3'(NPORT-1)) ? P_CORE : sel[o] + 3'd1;
                    end
                end else if (in_ack[o]) begin
                    oval[o] <= 1'b0;
                end
            end
        end
    end
endmodule
